// File: rtl/weight_seq_ctrl.sv
// Weight memory controller: loads N host weights, then streams them to the MAC datapath.
// Stream latency is two cycles from start to first w_valid; w_ready=0 stalls reads via a 2-entry buffer.
module weight_seq_ctrl #(
   parameter int DW    = 8,
   parameter int AW    = 4,
   parameter int DEPTH = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load_start,
   input  logic [AW:0]   n_weights,
   input  logic          s_valid,
   input  logic [DW-1:0] s_data,
   output logic          s_ready,
   input  logic          start,
   output logic          w_valid,
   output logic [DW-1:0] w_data,
   output logic          w_last,
   input  logic          w_ready,
   output logic          busy,
   output logic          loaded,
   output logic          err,
   output logic          mem_wr,
   output logic          mem_rd,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_data,
   input  logic [DW-1:0] mem_rdata
);

   localparam int PW = AW + 1;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_LOADED, S_STREAM} state_t;

   state_t             state_q, state_d;
   logic [PW-1:0]      n_q, n_d;
   logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
   logic               loaded_q, loaded_d;
   logic               err_q, err_d;
   logic               mem_wr_q, mem_wr_d;
   logic [AW-1:0]      wr_addr_q, wr_addr_d;
   logic [DW-1:0]      wr_dat_q, wr_dat_d;
   logic               rd_pend_q, rd_pend_d;
   logic               rd_last_q, rd_last_d;
   logic [1:0][DW-1:0] buf_dat_q, buf_dat_d;
   logic [1:0]         buf_last_q, buf_last_d;
   logic [1:0]         buf_cnt_q, buf_cnt_d;

   logic       n_ok;
   logic       load_go;
   logic       stream_go;
   logic       s_hs;
   logic       last_wr;
   logic       w_pop;
   logic [1:0] occ;

   assign n_ok = (n_weights != '0) && (n_weights <= PW'(DEPTH));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      err_d     = 1'b0;
      load_go   = 1'b0;
      stream_go = 1'b0;
      case (state_q)
         S_IDLE: begin
            err_d = start;
            if (load_start) begin
               if (n_ok) begin
                  load_go = 1'b1;
                  state_d = S_LOAD;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_LOADED: begin
            // start takes priority; a simultaneous load_start is flagged and dropped
            if (start) begin
               stream_go = 1'b1;
               state_d   = S_STREAM;
               err_d     = load_start;
            end else if (load_start) begin
               if (n_ok) begin
                  load_go = 1'b1;
                  state_d = S_LOAD;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_LOAD: begin
            err_d = start | load_start;
            if (last_wr) state_d = S_LOADED;
         end
         S_STREAM: begin
            err_d = start | load_start;
            if (w_pop && w_last) state_d = S_LOADED;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      s_ready  = (state_q == S_LOAD);
      busy     = (state_q == S_LOAD) || (state_q == S_STREAM);
      loaded   = loaded_q;
      err      = err_q;
      w_valid  = (buf_cnt_q != 2'd0);
      w_data   = buf_dat_q[0];
      w_last   = w_valid & buf_last_q[0];
      w_pop    = w_valid & w_ready;
      s_hs     = s_valid & s_ready;
      last_wr  = s_hs && (wr_ptr_q == n_q - PW'(1));
      // Credit the word leaving this cycle so a ready sink sees one weight per cycle.
      occ      = buf_cnt_q + {1'b0, rd_pend_q} - {1'b0, w_pop};
      mem_rd   = (state_q == S_STREAM) && (rd_ptr_q < n_q) && (occ < 2'd2);
      mem_addr = mem_rd ? rd_ptr_q[AW-1:0] : wr_addr_q;
      mem_wr   = mem_wr_q;
      mem_data = wr_dat_q;
   end

   always_comb begin
      n_d        = n_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      loaded_d   = loaded_q;
      wr_addr_d  = wr_addr_q;
      wr_dat_d   = wr_dat_q;
      mem_wr_d   = s_hs;
      rd_pend_d  = mem_rd;
      rd_last_d  = mem_rd && (rd_ptr_q == n_q - PW'(1));
      buf_dat_d  = buf_dat_q;
      buf_last_d = buf_last_q;
      buf_cnt_d  = buf_cnt_q + {1'b0, rd_pend_q} - {1'b0, w_pop};

      if (load_go) begin
         n_d      = n_weights;
         wr_ptr_d = '0;
         loaded_d = 1'b0;
      end
      if (s_hs) begin
         wr_ptr_d  = wr_ptr_q + PW'(1);
         wr_addr_d = wr_ptr_q[AW-1:0];
         wr_dat_d  = s_data;
      end
      if (last_wr) loaded_d = 1'b1;
      if (stream_go) rd_ptr_d = '0;
      if (mem_rd) rd_ptr_d = rd_ptr_q + PW'(1);

      if (w_pop) begin
         buf_dat_d[0]  = buf_dat_q[1];
         buf_last_d[0] = buf_last_q[1];
      end
      if (rd_pend_q) begin
         if (buf_cnt_q - {1'b0, w_pop} == 2'd0) begin
            buf_dat_d[0]  = mem_rdata;
            buf_last_d[0] = rd_last_q;
         end else begin
            buf_dat_d[1]  = mem_rdata;
            buf_last_d[1] = rd_last_q;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n_q        <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         loaded_q   <= 1'b0;
         err_q      <= 1'b0;
         mem_wr_q   <= 1'b0;
         wr_addr_q  <= '0;
         wr_dat_q   <= '0;
         rd_pend_q  <= 1'b0;
         rd_last_q  <= 1'b0;
         buf_dat_q  <= '0;
         buf_last_q <= '0;
         buf_cnt_q  <= '0;
      end else begin
         n_q        <= n_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         loaded_q   <= loaded_d;
         err_q      <= err_d;
         mem_wr_q   <= mem_wr_d;
         wr_addr_q  <= wr_addr_d;
         wr_dat_q   <= wr_dat_d;
         rd_pend_q  <= rd_pend_d;
         rd_last_q  <= rd_last_d;
         buf_dat_q  <= buf_dat_d;
         buf_last_q <= buf_last_d;
         buf_cnt_q  <= buf_cnt_d;
      end
   end

endmodule

// File: tb/tb_weight_seq_ctrl.sv
// Directed bench for weight_seq_ctrl: per-cycle vector table plus sequences for stalls, errors and reset.
module tb_weight_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       load_start;
   logic [4:0] n_weights;
   logic       s_valid;
   logic [7:0] s_data;
   logic       s_ready;
   logic       start;
   logic       w_valid;
   logic [7:0] w_data;
   logic       w_last;
   logic       w_ready;
   logic       busy;
   logic       loaded;
   logic       err;
   logic       mem_wr;
   logic       mem_rd;
   logic [3:0] mem_addr;
   logic [7:0] mem_data;
   logic [7:0] mem_rdata;

   always #5 clk = ~clk;

   weight_seq_ctrl #(.DW(8), .AW(4), .DEPTH(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .load_start(load_start), .n_weights(n_weights),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .start(start),
      .w_valid(w_valid), .w_data(w_data), .w_last(w_last), .w_ready(w_ready),
      .busy(busy), .loaded(loaded), .err(err),
      .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr),
      .mem_data(mem_data), .mem_rdata(mem_rdata)
   );

   // Synchronous-read weight memory
   logic [7:0] mem [16];
   int         mem_wr_cnt = 0;
   always @(posedge clk) begin
      if (mem_wr) begin
         mem[mem_addr] <= mem_data;
         mem_wr_cnt    <= mem_wr_cnt + 1;
      end
      if (mem_rd) mem_rdata <= mem[mem_addr];
   end

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct packed {
      logic       ld;
      logic [4:0] n;
      logic       sv;
      logic [7:0] sd;
      logic       st;
      logic       wr;
      logic       e_srdy;
      logic       e_busy;
      logic       e_loaded;
      logic       e_err;
      logic       e_mwr;
      logic       e_mrd;
      logic [3:0] e_addr;
      logic [7:0] e_mdata;
      logic       e_wv;
      logic [7:0] e_wd;
      logic       e_wl;
   } vec_t;

   function automatic vec_t v(input logic ld, input logic [4:0] n, input logic sv,
                              input logic [7:0] sd, input logic st, input logic wr,
                              input logic e_srdy, input logic e_busy, input logic e_loaded,
                              input logic e_err, input logic e_mwr, input logic e_mrd,
                              input logic [3:0] e_addr, input logic [7:0] e_mdata,
                              input logic e_wv, input logic [7:0] e_wd, input logic e_wl);
      vec_t r;
      r.ld = ld; r.n = n; r.sv = sv; r.sd = sd; r.st = st; r.wr = wr;
      r.e_srdy = e_srdy; r.e_busy = e_busy; r.e_loaded = e_loaded; r.e_err = e_err;
      r.e_mwr = e_mwr; r.e_mrd = e_mrd; r.e_addr = e_addr; r.e_mdata = e_mdata;
      r.e_wv = e_wv; r.e_wd = e_wd; r.e_wl = e_wl;
      return r;
   endfunction

   vec_t       tbl [13];
   logic [7:0] exp_d [16];
   logic [7:0] got_d [16];
   logic       got_l [16];
   int         got_n;
   int         first_vc;

   task automatic do_reset();
      load_start = 0; n_weights = 0; s_valid = 0; s_data = 0; start = 0; w_ready = 0;
      rst_n = 0;
      @(posedge clk);
      #1 rst_n = 1;
   endtask

   task automatic do_load(input int n);
      load_start = 1;
      n_weights  = 5'(n);
      tick();
      load_start = 0;
      for (int i = 0; i < n; i++) begin
         s_valid = 1;
         s_data  = exp_d[i];
         tick();
      end
      s_valid = 0;
   endtask

   // mode 0: w_ready held high; mode 1: w_ready repeats 1,0,0,1
   task automatic do_stream(input int stop, input bit mode, input bit post);
      logic       prev_stall;
      logic [7:0] prev_d;
      logic       prev_l;
      got_n      = 0;
      first_vc   = -1;
      prev_stall = 0;
      prev_d     = 0;
      prev_l     = 0;
      start      = 1;
      for (int c = 0; c < 200 && got_n < stop; c++) begin
         @(posedge clk);
         #1;
         start   = 0;
         w_ready = mode ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
         #1;
         if (prev_stall) chk("stall_hold", {w_valid, w_last, w_data}, {1'b1, prev_l, prev_d});
         if (w_valid && first_vc < 0) first_vc = c;
         prev_stall = w_valid && !w_ready;
         prev_d     = w_data;
         prev_l     = w_last;
         if (w_valid && w_ready) begin
            got_d[got_n] = w_data;
            got_l[got_n] = w_last;
            got_n++;
         end
      end
      chk("stream_count", got_n, stop);
      if (post) begin
         @(posedge clk);
         #2;
         chk("post_busy", busy, 0);
         chk("post_loaded", loaded, 1);
      end
   endtask

   task automatic verify_seq(input int n);
      for (int i = 0; i < n; i++) begin
         chk($sformatf("seq_data[%0d]", i), got_d[i], exp_d[i]);
         chk($sformatf("seq_last[%0d]", i), got_l[i], (i == n - 1));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //          ld n  sv sd     st wr  srdy busy ldd err mwr mrd addr mdata  wv wd     wl
      tbl[0]  = v(1, 4, 0, 8'h00, 0, 0,  0,   0,   0,  0,  0,  0,  0,   8'h00, 0, 8'h00, 0);
      tbl[1]  = v(0, 4, 1, 8'h11, 0, 0,  1,   1,   0,  0,  0,  0,  0,   8'h00, 0, 8'h00, 0);
      tbl[2]  = v(0, 4, 1, 8'h22, 0, 0,  1,   1,   0,  0,  1,  0,  0,   8'h11, 0, 8'h00, 0);
      tbl[3]  = v(0, 4, 1, 8'h33, 0, 0,  1,   1,   0,  0,  1,  0,  1,   8'h22, 0, 8'h00, 0);
      tbl[4]  = v(0, 4, 1, 8'h44, 0, 0,  1,   1,   0,  0,  1,  0,  2,   8'h33, 0, 8'h00, 0);
      tbl[5]  = v(0, 4, 0, 8'h00, 1, 1,  0,   0,   1,  0,  1,  0,  3,   8'h44, 0, 8'h00, 0);
      tbl[6]  = v(0, 4, 0, 8'h00, 0, 1,  0,   1,   1,  0,  0,  1,  0,   8'h00, 0, 8'h00, 0);
      tbl[7]  = v(0, 4, 0, 8'h00, 0, 1,  0,   1,   1,  0,  0,  1,  1,   8'h00, 0, 8'h00, 0);
      tbl[8]  = v(0, 4, 0, 8'h00, 0, 1,  0,   1,   1,  0,  0,  1,  2,   8'h00, 1, 8'h11, 0);
      tbl[9]  = v(0, 4, 0, 8'h00, 0, 1,  0,   1,   1,  0,  0,  1,  3,   8'h00, 1, 8'h22, 0);
      tbl[10] = v(0, 4, 0, 8'h00, 0, 1,  0,   1,   1,  0,  0,  0,  0,   8'h00, 1, 8'h33, 0);
      tbl[11] = v(0, 4, 0, 8'h00, 0, 1,  0,   1,   1,  0,  0,  0,  0,   8'h00, 1, 8'h44, 1);
      tbl[12] = v(0, 4, 0, 8'h00, 0, 1,  0,   0,   1,  0,  0,  0,  0,   8'h00, 0, 8'h00, 0);

      load_start = 0; n_weights = 0; s_valid = 0; s_data = 0; start = 0; w_ready = 0;
      rst_n = 0;
      #1;
      chk("reset_outputs", {s_ready, w_valid, w_data, w_last, busy, loaded, err,
                            mem_wr, mem_rd, mem_addr, mem_data}, 0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1;

      // Load 0x11..0x44 and stream with w_ready high, cycle by cycle
      for (int i = 0; i < 13; i++) begin
         @(posedge clk);
         #1;
         load_start = tbl[i].ld; n_weights = tbl[i].n; s_valid = tbl[i].sv;
         s_data = tbl[i].sd; start = tbl[i].st; w_ready = tbl[i].wr;
         #1;
         chk($sformatf("t1[%0d].s_ready", i), s_ready, tbl[i].e_srdy);
         chk($sformatf("t1[%0d].busy", i), busy, tbl[i].e_busy);
         chk($sformatf("t1[%0d].loaded", i), loaded, tbl[i].e_loaded);
         chk($sformatf("t1[%0d].err", i), err, tbl[i].e_err);
         chk($sformatf("t1[%0d].mem_wr", i), mem_wr, tbl[i].e_mwr);
         chk($sformatf("t1[%0d].mem_rd", i), mem_rd, tbl[i].e_mrd);
         if (tbl[i].e_mwr || tbl[i].e_mrd) chk($sformatf("t1[%0d].mem_addr", i), mem_addr, tbl[i].e_addr);
         if (tbl[i].e_mwr) chk($sformatf("t1[%0d].mem_data", i), mem_data, tbl[i].e_mdata);
         chk($sformatf("t1[%0d].w_valid", i), w_valid, tbl[i].e_wv);
         if (tbl[i].e_wv) chk($sformatf("t1[%0d].w_data", i), w_data, tbl[i].e_wd);
         chk($sformatf("t1[%0d].w_last", i), w_last, tbl[i].e_wl);
      end
      w_ready = 0;
      start   = 0;

      // N=16 with a stuttering sink
      for (int i = 0; i < 16; i++) exp_d[i] = 8'(i * 3);
      do_load(16);
      do_stream(16, 1, 1);
      verify_seq(16);

      // Illegal weight counts from IDLE
      do_reset();
      begin
         int wr_before;
         wr_before  = mem_wr_cnt;
         s_valid    = 1;
         s_data     = 8'hAA;
         load_start = 1;
         n_weights  = 5'd0;
         tick();
         load_start = 0;
         #1;
         chk("n0_err", err, 1);
         chk("n0_s_ready", s_ready, 0);
         chk("n0_busy", busy, 0);
         tick();
         chk("n0_err_pulse", err, 0);
         load_start = 1;
         n_weights  = 5'd17;
         tick();
         load_start = 0;
         #1;
         chk("n17_err", err, 1);
         chk("n17_s_ready", s_ready, 0);
         tick();
         chk("n17_err_pulse", err, 0);
         chk("n17_busy", busy, 0);
         tick();
         chk("bad_n_no_write", mem_wr_cnt, wr_before);
         s_valid = 0;
      end

      // start in the middle of a load
      exp_d[0] = 8'h51; exp_d[1] = 8'h52; exp_d[2] = 8'h53; exp_d[3] = 8'h54;
      load_start = 1;
      n_weights  = 5'd4;
      tick();
      load_start = 0;
      s_valid = 1; s_data = 8'h51; tick();
      s_data = 8'h52; tick();
      s_data = 8'h53; start = 1; tick();
      start = 0;
      #1;
      chk("load_start_err", err, 1);
      chk("load_cont_busy", busy, 1);
      chk("load_cont_s_ready", s_ready, 1);
      s_data = 8'h54;
      tick();
      s_valid = 0;
      #1;
      chk("load_done_loaded", loaded, 1);
      chk("load_done_busy", busy, 0);
      do_stream(4, 0, 1);
      verify_seq(4);

      // Restream N=3 twice
      exp_d[0] = 8'hA1; exp_d[1] = 8'hA2; exp_d[2] = 8'hA3;
      do_load(3);
      do_stream(3, 0, 1);
      chk("restream1_latency", first_vc, 2);
      verify_seq(3);
      do_stream(3, 0, 1);
      chk("restream2_latency", first_vc, 2);
      verify_seq(3);

      // Reset in the middle of a stream
      for (int i = 0; i < 8; i++) exp_d[i] = 8'h80 + 8'(i);
      do_load(8);
      do_stream(5, 0, 0);
      for (int i = 0; i < 5; i++) chk($sformatf("pre_reset_data[%0d]", i), got_d[i], exp_d[i]);
      @(posedge clk);
      #3;
      rst_n = 0;
      #1;
      chk("mid_reset_outputs", {s_ready, w_valid, w_data, w_last, busy, loaded, err,
                                mem_wr, mem_rd, mem_addr, mem_data}, 0);
      @(posedge clk);
      #1 rst_n = 1;
      w_ready = 0;
      #1;
      chk("after_reset_busy", busy, 0);
      chk("after_reset_loaded", loaded, 0);
      start = 1;
      tick();
      start = 0;
      #1;
      chk("after_reset_start_err", err, 1);
      chk("after_reset_idle", busy, 0);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
